decode_exec_write: RTL and testbench

DECODE_EXEC_WRITE -- requirements
Module: decode_exec_write

---
 rtl/decode_exec_write_pkg.sv | 127 ++++++++++++
 rtl/decode_exec_write_if.sv | 37 +++
 rtl/decoder.sv | 141 ++++++++++++++
 rtl/executer.sv | 118 +++++++++++
 rtl/writer.sv | 26 ++
 rtl/decode_exec_write.sv | 64 ++++++
 tb/tb_decode_exec_write.sv | 269 ++++++++++++++++++++++++++
 7 files changed

// File: rtl/decode_exec_write_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_exec_write_pkg
// Purpose  : Shared RV32I opcode/funct constants, op-class and ALU enums,
//            the control_info record passed from decode to execute, and
//            ALU helper functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package decode_exec_write_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [2:0] F3_WORD    = 3'b010;   // LW / SW
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [3:0] {
        CLS_NOP    = 4'd0,
        CLS_OP     = 4'd1,
        CLS_OPIMM  = 4'd2,
        CLS_LUI    = 4'd3,
        CLS_AUIPC  = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_BRANCH = 4'd7,
        CLS_JAL    = 4'd8,
        CLS_JALR   = 4'd9
    } op_class_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        op_class_t   op;
        alu_op_t     alu;
        logic [2:0]  funct3;
        logic        wr;
    } control_info_t;

    localparam control_info_t NOP_CTRL = '{
        pc: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0,
        op: CLS_NOP, alu: ALU_ADD, funct3: 3'd0, wr: 1'b0
    };

    // is_reg separates SUB (register form only) from ADDI, whose bit 30 is
    // just part of the immediate.
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt,
                                           input logic is_reg);
        alu_op_t r;
        r = ALU_ADD;
        case (f3)
            F3_ADD_SUB: r = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            F3_SLL:     r = ALU_SLL;
            F3_SLT:     r = ALU_SLT;
            F3_SLTU:    r = ALU_SLTU;
            F3_XOR:     r = ALU_XOR;
            F3_SRL_SRA: r = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      r = ALU_OR;
            default:    r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_exec_write_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_exec_write_if
// Purpose  : Bundle of the stage enables, instruction/PC/register-file
//            inputs and the jump/write-back outputs of decode_exec_write.
// Ports    : master - drives enables, INSTRUCTION, PC, REGISTER_FILE
//            slave  - the pipeline; drives CONDITIONAL_JUMP, JUMP_DEST,
//                     WRITE_ENABLE, WRITE_DATA, WB_RD, WB_PC
// Revision : 1.0 - initial release
// ============================================================================
interface decode_exec_write_if;
    logic              DECODER_ENABLED;
    logic              EXECUTER_ENABLED;
    logic              WRITER_ENABLED;
    logic [31:0]       INSTRUCTION;
    logic [31:0]       PC;
    logic [31:0][31:0] REGISTER_FILE;
    logic              CONDITIONAL_JUMP;
    logic [31:0]       JUMP_DEST;
    logic              WRITE_ENABLE;
    logic [31:0]       WRITE_DATA;
    logic [4:0]        WB_RD;
    logic [31:0]       WB_PC;

    modport master (
        output DECODER_ENABLED, EXECUTER_ENABLED, WRITER_ENABLED,
        output INSTRUCTION, PC, REGISTER_FILE,
        input  CONDITIONAL_JUMP, JUMP_DEST, WRITE_ENABLE, WRITE_DATA, WB_RD, WB_PC
    );

    modport slave (
        input  DECODER_ENABLED, EXECUTER_ENABLED, WRITER_ENABLED,
        input  INSTRUCTION, PC, REGISTER_FILE,
        output CONDITIONAL_JUMP, JUMP_DEST, WRITE_ENABLE, WRITE_DATA, WB_RD, WB_PC
    );
endinterface
`default_nettype wire

// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
// Module   : decoder
// Purpose  : Decode stage. Cracks an RV32I word into a control_info record
//            and registers it; unsupported encodings become NOPs.
// Ports    : clk, rst (sync, active-high), enabled (0 = bubble),
//            instruction, pc -> ctrl (registered), conditional_jump
// Revision : 1.0 - initial release
// ============================================================================
module decoder
    import decode_exec_write_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          enabled,
    input  logic [31:0]   instruction,
    input  logic [31:0]   pc,
    output control_info_t ctrl,
    output logic          conditional_jump
);
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    control_info_t next;

    assign opcode = instruction[6:0];
    assign rd_f   = instruction[11:7];
    assign f3     = instruction[14:12];
    assign rs1_f  = instruction[19:15];
    assign rs2_f  = instruction[24:20];
    assign f7     = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'd0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        next    = NOP_CTRL;
        next.pc = pc;              // bubbles keep the PC so JUMP_DEST stays sensible
        if (enabled) begin
            case (opcode)
                OPC_OP: begin
                    if (f7 == F7_BASE ||
                        (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))) begin
                        next.op  = CLS_OP;
                        next.alu = alu_decode(f3, instruction[30], 1'b1);
                        next.rd  = rd_f;
                        next.rs1 = rs1_f;
                        next.rs2 = rs2_f;
                        next.wr  = 1'b1;
                    end
                end
                OPC_OPIMM: begin
                    if ((f3 != F3_SLL && f3 != F3_SRL_SRA) ||
                        (f3 == F3_SLL && f7 == F7_BASE) ||
                        (f3 == F3_SRL_SRA && (f7 == F7_BASE || f7 == F7_ALT))) begin
                        next.op  = CLS_OPIMM;
                        next.alu = alu_decode(f3, instruction[30], 1'b0);
                        next.rd  = rd_f;
                        next.rs1 = rs1_f;
                        next.imm = imm_i;
                        next.wr  = 1'b1;
                    end
                end
                OPC_LUI, OPC_AUIPC: begin
                    next.op  = (opcode == OPC_LUI) ? CLS_LUI : CLS_AUIPC;
                    next.rd  = rd_f;
                    next.imm = imm_u;
                    next.wr  = 1'b1;
                end
                OPC_LOAD: begin
                    if (f3 == F3_WORD) begin
                        next.op  = CLS_LOAD;
                        next.rd  = rd_f;
                        next.rs1 = rs1_f;
                        next.imm = imm_i;
                        next.wr  = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (f3 == F3_WORD) begin
                        next.op  = CLS_STORE;
                        next.rs1 = rs1_f;
                        next.rs2 = rs2_f;
                        next.imm = imm_s;
                    end
                end
                OPC_BRANCH: begin
                    if (f3 != 3'b010 && f3 != 3'b011) begin
                        next.op     = CLS_BRANCH;
                        next.rs1    = rs1_f;
                        next.rs2    = rs2_f;
                        next.imm    = imm_b;
                        next.funct3 = f3;
                    end
                end
                OPC_JAL: begin
                    next.op  = CLS_JAL;
                    next.rd  = rd_f;
                    next.imm = imm_j;
                    next.wr  = 1'b1;
                end
                OPC_JALR: begin
                    if (f3 == F3_JALR) begin
                        next.op  = CLS_JALR;
                        next.rd  = rd_f;
                        next.rs1 = rs1_f;
                        next.imm = imm_i;
                        next.wr  = 1'b1;
                    end
                end
                default: next = next;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= NOP_CTRL;
        end else begin
            ctrl <= next;
        end
    end

    assign conditional_jump = (ctrl.op == CLS_BRANCH) || (ctrl.op == CLS_JAL) ||
                              (ctrl.op == CLS_JALR);

endmodule
`default_nettype wire

// File: rtl/executer.sv
`default_nettype none
// ============================================================================
// Module   : executer
// Purpose  : Execute stage. Reads operands (with forwarding from the write
//            stage), computes ALU/branch/jump results, owns the 256-word
//            data memory and registers the write-back record.
// Ports    : clk, rst, enabled (0 = hold, block stores), ctrl,
//            register_file, fwd_en/fwd_rd/fwd_data (write-stage bypass)
//            -> result, rd, wr, pc, jump_dest (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module executer
    import decode_exec_write_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enabled,
    input  control_info_t     ctrl,
    input  logic [31:0][31:0] register_file,
    input  logic              fwd_en,
    input  logic [4:0]        fwd_rd,
    input  logic [31:0]       fwd_data,
    output logic [31:0]       result,
    output logic [4:0]        rd,
    output logic              wr,
    output logic [31:0]       pc,
    output logic [31:0]       jump_dest
);
    logic [31:0] mem [256];
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm_words;
    logic [7:0]  mem_index;
    logic        taken;
    logic [31:0] next_result;
    logic [31:0] next_jd;

    // x0 always reads zero; otherwise the write stage overrides a stale
    // register-file value for back-to-back dependencies.
    always_comb begin
        op_a = 32'd0;
        op_b = 32'd0;
        if (ctrl.rs1 != 5'd0) begin
            op_a = (fwd_en && fwd_rd == ctrl.rs1) ? fwd_data : register_file[ctrl.rs1];
        end
        if (ctrl.rs2 != 5'd0) begin
            op_b = (fwd_en && fwd_rd == ctrl.rs2) ? fwd_data : register_file[ctrl.rs2];
        end
    end

    // PC counts words, so byte offsets are scaled down arithmetically.
    assign imm_words = {{2{ctrl.imm[31]}}, ctrl.imm[31:2]};
    assign mem_index = 8'((op_a + ctrl.imm) >> 2);

    always_comb begin
        taken = 1'b0;
        case (ctrl.funct3)
            F3_BEQ:  taken = (op_a == op_b);
            F3_BNE:  taken = (op_a != op_b);
            F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: taken = (op_a <  op_b);
            F3_BGEU: taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_result = 32'd0;
        next_jd     = ctrl.pc + 32'd1;
        case (ctrl.op)
            CLS_OP:     next_result = alu_calc(ctrl.alu, op_a, op_b);
            CLS_OPIMM:  next_result = alu_calc(ctrl.alu, op_a, ctrl.imm);
            CLS_LUI:    next_result = ctrl.imm;
            // AUIPC yields a byte address built from the word PC.
            CLS_AUIPC:  next_result = {ctrl.pc[29:0], 2'b00} + ctrl.imm;
            CLS_BRANCH: begin
                if (taken) begin
                    next_jd = ctrl.pc + imm_words;
                end
            end
            CLS_JAL: begin
                next_result = ctrl.pc + 32'd1;
                next_jd     = ctrl.pc + imm_words;
            end
            CLS_JALR: begin
                next_result = ctrl.pc + 32'd1;
                next_jd     = op_a + imm_words;
            end
            default: next_result = 32'd0;
        endcase
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && enabled && ctrl.op == CLS_STORE) begin
            mem[mem_index] <= op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= 32'd0;
            rd        <= 5'd0;
            wr        <= 1'b0;
            pc        <= 32'd0;
            jump_dest <= 32'd0;
        end else if (enabled) begin
            result    <= (ctrl.op == CLS_LOAD) ? mem[mem_index] : next_result;
            rd        <= ctrl.rd;
            wr        <= ctrl.wr;
            pc        <= ctrl.pc;
            jump_dest <= next_jd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/writer.sv
`default_nettype none
// ============================================================================
// Module   : writer
// Purpose  : Write stage. Purely combinational view of the execute
//            registers, gating the register-file write strobe.
// Ports    : enabled (0 = no write), result, rd, wr, pc
//            -> write_enable, write_data, wb_rd, wb_pc
// Revision : 1.0 - initial release
// ============================================================================
module writer (
    input  logic        enabled,
    input  logic [31:0] result,
    input  logic [4:0]  rd,
    input  logic        wr,
    input  logic [31:0] pc,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_pc
);
    assign write_enable = wr && (rd != 5'd0) && enabled;
    assign write_data   = result;
    assign wb_rd        = rd;
    assign wb_pc        = pc;
endmodule
`default_nettype wire

// File: rtl/decode_exec_write.sv
`default_nettype none
// ============================================================================
// Module   : decode_exec_write
// Purpose  : Three-stage RV32I decode / execute / write pipeline slice.
//            INSTRUCTION reaches WRITE_DATA two rising edges later.
// Ports    : CLK, RSTN (sync, active-high reset),
//            bus (slave) - enables, INSTRUCTION, PC, REGISTER_FILE in;
//                          CONDITIONAL_JUMP, JUMP_DEST, WRITE_ENABLE,
//                          WRITE_DATA, WB_RD, WB_PC out
// Revision : 1.0 - initial release
// ============================================================================
module decode_exec_write
    import decode_exec_write_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTN,
    decode_exec_write_if.slave  bus
);
    control_info_t dec_ctrl;
    logic [31:0]   ex_result;
    logic [4:0]    ex_rd;
    logic          ex_wr;
    logic [31:0]   ex_pc;

    decoder u_decoder (
        .clk              (CLK),
        .rst              (RSTN),
        .enabled          (bus.DECODER_ENABLED),
        .instruction      (bus.INSTRUCTION),
        .pc               (bus.PC),
        .ctrl             (dec_ctrl),
        .conditional_jump (bus.CONDITIONAL_JUMP)
    );

    executer u_executer (
        .clk           (CLK),
        .rst           (RSTN),
        .enabled       (bus.EXECUTER_ENABLED),
        .ctrl          (dec_ctrl),
        .register_file (bus.REGISTER_FILE),
        .fwd_en        (bus.WRITE_ENABLE),
        .fwd_rd        (bus.WB_RD),
        .fwd_data      (bus.WRITE_DATA),
        .result        (ex_result),
        .rd            (ex_rd),
        .wr            (ex_wr),
        .pc            (ex_pc),
        .jump_dest     (bus.JUMP_DEST)
    );

    writer u_writer (
        .enabled      (bus.WRITER_ENABLED),
        .result       (ex_result),
        .rd           (ex_rd),
        .wr           (ex_wr),
        .pc           (ex_pc),
        .write_enable (bus.WRITE_ENABLE),
        .write_data   (bus.WRITE_DATA),
        .wb_rd        (bus.WB_RD),
        .wb_pc        (bus.WB_PC)
    );

endmodule
`default_nettype wire

// File: tb/tb_decode_exec_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_exec_write
// Purpose  : Self-checking bench for decode_exec_write: a vector table run
//            through a latency-aware scoreboard, then hand-written sequences
//            for forwarding, memory, stage enables and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_exec_write;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    decode_exec_write_if bus ();

    decode_exec_write dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        cj;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] jd;
    } vec_t;

    typedef struct {
        int          idx;
        int          ready;
        logic        cj;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] wpc;
        logic [31:0] jd;
    } exp_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];
    exp_t q_cj [$];
    exp_t q_wb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [31:0] nop_i = 32'h0000_0013;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v, input int idx);
        exp_t e;
        bus.INSTRUCTION = v.instr;
        bus.PC          = v.pc;
        e.idx = idx; e.cj = v.cj; e.we = v.we; e.data = v.data; e.chk_data = v.chk_data;
        e.rd = v.rd; e.wpc = v.pc; e.jd = v.jd;
        e.ready = cyc + 1;
        q_cj.push_back(e);
        e.ready = cyc + 2;
        q_wb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (q_cj.size() > 0 && q_cj[0].ready == cyc) begin
            e = q_cj.pop_front();
            check("cond_jump", e.idx, 32'(bus.CONDITIONAL_JUMP), 32'(e.cj));
        end
        if (q_wb.size() > 0 && q_wb[0].ready == cyc) begin
            e = q_wb.pop_front();
            check("write_enable", e.idx, 32'(bus.WRITE_ENABLE), 32'(e.we));
            check("wb_rd", e.idx, 32'(bus.WB_RD), 32'(e.rd));
            check("wb_pc", e.idx, bus.WB_PC, e.wpc);
            check("jump_dest", e.idx, bus.JUMP_DEST, e.jd);
            if (e.chk_data) check("write_data", e.idx, bus.WRITE_DATA, e.data);
        end
    endtask

    task automatic put(input logic [31:0] instr, input logic [31:0] pc);
        bus.INSTRUCTION = instr;
        bus.PC          = pc;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rf[i] = i throughout the table; only adjacent instructions forward.
        vecs[0]  = '{enc_i(12'd500, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'd3, 1'b0, 1'b1, 32'd500, 1'b1, 5'd2, 32'd4};
        vecs[1]  = '{enc_j(21'h74, 5'd1), 32'd0, 1'b1, 1'b1, 32'd1, 1'b1, 5'd1, 32'd29};
        vecs[2]  = '{enc_b(13'd12, 5'd10, 5'd1, 3'b100), 32'd9, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd12};
        vecs[3]  = '{enc_b(13'd12, 5'd1, 5'd1, 3'b100), 32'd9, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd10};
        vecs[4]  = '{enc_r(7'h00, 5'd4, 5'd3, 3'b000, 5'd20), 32'd20, 1'b0, 1'b1, 32'd7, 1'b1, 5'd20, 32'd21};
        vecs[5]  = '{enc_r(7'h20, 5'd4, 5'd3, 3'b000, 5'd21), 32'd21, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd21, 32'd22};
        vecs[6]  = '{enc_r(7'h00, 5'd6, 5'd5, 3'b111, 5'd22), 32'd22, 1'b0, 1'b1, 32'd4, 1'b1, 5'd22, 32'd23};
        vecs[7]  = '{enc_r(7'h00, 5'd6, 5'd5, 3'b110, 5'd23), 32'd23, 1'b0, 1'b1, 32'd7, 1'b1, 5'd23, 32'd24};
        vecs[8]  = '{enc_r(7'h00, 5'd6, 5'd5, 3'b100, 5'd24), 32'd24, 1'b0, 1'b1, 32'd3, 1'b1, 5'd24, 32'd25};
        vecs[9]  = '{enc_i(12'd4, 5'd3, 3'b001, 5'd25, 7'b0010011), 32'd25, 1'b0, 1'b1, 32'd48, 1'b1, 5'd25, 32'd26};
        vecs[10] = '{enc_r(7'h00, 5'd4, 5'd3, 3'b010, 5'd26), 32'd26, 1'b0, 1'b1, 32'd1, 1'b1, 5'd26, 32'd27};
        vecs[11] = '{enc_r(7'h00, 5'd3, 5'd4, 3'b011, 5'd27), 32'd27, 1'b0, 1'b1, 32'd0, 1'b1, 5'd27, 32'd28};
        vecs[12] = '{enc_i(12'hFFA, 5'd5, 3'b000, 5'd28, 7'b0010011), 32'd28, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd28, 32'd29};
        vecs[13] = '{enc_i(12'h401, 5'd28, 3'b101, 5'd29, 7'b0010011), 32'd29, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd29, 32'd30};
        vecs[14] = '{enc_r(7'h00, 5'd1, 5'd28, 3'b101, 5'd30), 32'd30, 1'b0, 1'b1, 32'd14, 1'b1, 5'd30, 32'd31};
        vecs[15] = '{{20'h12345, 5'd31, 7'b0110111}, 32'd31, 1'b0, 1'b1, 32'h1234_5000, 1'b1, 5'd31, 32'd32};
        vecs[16] = '{enc_b(13'h1FF8, 5'd4, 5'd3, 3'b111), 32'd40, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd41};
        vecs[17] = '{enc_b(13'h1FF8, 5'd4, 5'd3, 3'b001), 32'd40, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd38};
        vecs[18] = '{enc_i(12'd12, 5'd8, 3'b000, 5'd16, 7'b1100111), 32'd50, 1'b1, 1'b1, 32'd51, 1'b1, 5'd16, 32'd11};
        vecs[19] = '{32'hFFFF_FFFF, 32'd60, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd61};

        bus.DECODER_ENABLED  = 1'b1;
        bus.EXECUTER_ENABLED = 1'b1;
        bus.WRITER_ENABLED   = 1'b1;
        for (int i = 0; i < 32; i++) bus.REGISTER_FILE[i] = 32'(i);
        put(nop_i, 32'd0);

        // Reset state
        RSTN = 1'b1;
        tick();
        tick();
        check("rst_cond_jump", 0, 32'(bus.CONDITIONAL_JUMP), 32'd0);
        check("rst_write_enable", 0, 32'(bus.WRITE_ENABLE), 32'd0);
        check("rst_write_data", 0, bus.WRITE_DATA, 32'd0);
        check("rst_wb_rd", 0, 32'(bus.WB_RD), 32'd0);
        check("rst_wb_pc", 0, bus.WB_PC, 32'd0);
        check("rst_jump_dest", 0, bus.JUMP_DEST, 32'd0);
        RSTN = 1'b0;

        // Table through the scoreboard, back to back
        for (int i = 0; i < NVEC; i++) begin
            drive_vec(vecs[i], i);
            step();
        end
        put(nop_i, 32'd0);
        step();
        step();
        check("scoreboard_drained", 0, 32'(q_cj.size() + q_wb.size()), 32'd0);

        // Forwarding: ADDI x15,x0,1 then ADD x15,x15,x15 with rf[15]=0
        bus.REGISTER_FILE[15] = 32'd0;
        put(enc_i(12'd1, 5'd0, 3'b000, 5'd15, 7'b0010011), 32'd70);
        tick();
        put(enc_r(7'h00, 5'd15, 5'd15, 3'b000, 5'd15), 32'd71);
        tick();
        check("fwd_first_data", 0, bus.WRITE_DATA, 32'd1);
        put(nop_i, 32'd72);
        tick();
        check("fwd_second_data", 0, bus.WRITE_DATA, 32'd2);
        check("fwd_second_rd", 0, 32'(bus.WB_RD), 32'd15);
        check("fwd_second_we", 0, 32'(bus.WRITE_ENABLE), 32'd1);

        // Writer disabled: no write strobe, so no forwarding either
        put(enc_i(12'd1, 5'd0, 3'b000, 5'd15, 7'b0010011), 32'd73);
        tick();
        put(enc_r(7'h00, 5'd15, 5'd15, 3'b000, 5'd15), 32'd74);
        bus.WRITER_ENABLED = 1'b0;
        tick();
        check("wdis_write_enable", 0, 32'(bus.WRITE_ENABLE), 32'd0);
        put(nop_i, 32'd75);
        tick();
        check("wdis_no_forward", 0, bus.WRITE_DATA, 32'd0);
        bus.WRITER_ENABLED = 1'b1;
        #1;
        check("wen_restored", 0, 32'(bus.WRITE_ENABLE), 32'd1);

        // SW x10=7 to 480(x0) then LW x14 from 480
        bus.REGISTER_FILE[10] = 32'd7;
        bus.REGISTER_FILE[11] = 32'd99;
        put(enc_s(12'd480, 5'd10, 5'd0), 32'd80);
        tick();
        put(enc_i(12'd480, 5'd0, 3'b010, 5'd14, 7'b0000011), 32'd81);
        tick();
        put(nop_i, 32'd82);
        tick();
        check("lw_data", 0, bus.WRITE_DATA, 32'd7);
        check("lw_rd", 0, 32'(bus.WB_RD), 32'd14);
        check("lw_we", 0, 32'(bus.WRITE_ENABLE), 32'd1);

        // Executer disabled: registers hold and the pending SW is blocked
        put(enc_s(12'd480, 5'd11, 5'd0), 32'd90);
        tick();
        put(nop_i, 32'd91);
        bus.EXECUTER_ENABLED = 1'b0;
        tick();
        check("hold_wb_pc", 0, bus.WB_PC, 32'd82);
        bus.EXECUTER_ENABLED = 1'b1;
        put(enc_i(12'd480, 5'd0, 3'b010, 5'd14, 7'b0000011), 32'd92);
        tick();
        put(nop_i, 32'd93);
        tick();
        check("blocked_sw_data", 0, bus.WRITE_DATA, 32'd7);

        // Decoder disabled: JAL becomes a bubble
        bus.DECODER_ENABLED = 1'b0;
        put(enc_j(21'h74, 5'd1), 32'd0);
        tick();
        check("ddis_cond_jump", 0, 32'(bus.CONDITIONAL_JUMP), 32'd0);
        bus.DECODER_ENABLED = 1'b1;
        put(nop_i, 32'd1);
        tick();
        check("ddis_write_enable", 0, 32'(bus.WRITE_ENABLE), 32'd0);

        // Reset with JAL in execute and another JAL in decode
        put(enc_j(21'h74, 5'd1), 32'd0);
        tick();
        check("jal_cond_jump", 0, 32'(bus.CONDITIONAL_JUMP), 32'd1);
        put(enc_j(21'h74, 5'd1), 32'd5);
        tick();
        check("jal_we_before_rst", 0, 32'(bus.WRITE_ENABLE), 32'd1);
        check("jal_jd_before_rst", 0, bus.JUMP_DEST, 32'd29);
        RSTN = 1'b1;
        put(nop_i, 32'd6);
        tick();
        check("midrst_write_enable", 0, 32'(bus.WRITE_ENABLE), 32'd0);
        check("midrst_cond_jump", 0, 32'(bus.CONDITIONAL_JUMP), 32'd0);
        check("midrst_write_data", 0, bus.WRITE_DATA, 32'd0);
        check("midrst_jump_dest", 0, bus.JUMP_DEST, 32'd0);
        RSTN = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
